// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and operand-select codes for the Goldschmidt
//               divider sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Controller states; values are fixed so trace dumps stay stable.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL_N = 3'd2,
        S_MUL_D = 3'd3,
        S_REM   = 3'd4,
        S_ROUND = 3'd5,
        S_DONE  = 3'd6
    } div_state_t;

    // Multiplier A operand select codes.
    localparam logic [1:0] A_N    = 2'd0;
    localparam logic [1:0] A_D    = 2'd1;
    localparam logic [1:0] A_Q    = 2'd2;
    localparam logic [1:0] A_ZERO = 2'd3;

    // Multiplier B operand select codes.
    localparam logic B_K       = 1'b0;
    localparam logic B_DIVISOR = 1'b1;

    // Rounding mode encodings.
    localparam logic RM_NE = 1'b0;
    localparam logic RM_Z  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_if
// Description : Issue-side handshake and datapath control bundle of the
//               divider controller. master = issue logic / observer,
//               slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_ctrl_if #(
    parameter int ITERS = 4,
    parameter int CW    = $clog2(ITERS + 1)
);
    import div_pkg::*;

    logic          start;
    logic          rm;
    logic          busy;
    logic          done;
    logic [1:0]    mul_a_sel;
    logic          mul_b_sel;
    logic          ld_nd;
    logic          ld_n;
    logic          ld_d;
    logic          ld_rem;
    logic          round_en;
    logic          rnd_z;
    logic [CW-1:0] iter;

    modport master (
        output start, rm,
        input  busy, done, mul_a_sel, mul_b_sel, ld_nd, ld_n, ld_d,
               ld_rem, round_en, rnd_z, iter
    );

    modport slave (
        input  start, rm,
        output busy, done, mul_a_sel, mul_b_sel, ld_nd, ld_n, ld_d,
               ld_rem, round_en, rnd_z, iter
    );
endinterface
`default_nettype wire

// File: rtl/div_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_cnt
// Description : Goldschmidt iteration counter. Clears on a new divide,
//               increments once per completed N/D pair and saturates at
//               ITERS. last_iter flags the pair that finishes the loop.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_cnt
    import div_pkg::*;
#(
    parameter int ITERS = 4,
    parameter int CW    = $clog2(ITERS + 1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          clr,
    input  wire logic          inc,
    output logic [CW-1:0]      iter,
    output logic               last_iter
);

    localparam logic [CW-1:0] C_MAX  = CW'(ITERS);
    localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);

    logic [CW-1:0] r_iter;

    // Clear has priority; increments stop once the full count is reached.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_iter <= '0;
        end else if (clr) begin
            r_iter <= '0;
        end else if (inc && (r_iter != C_MAX)) begin
            r_iter <= r_iter + CW'(1);
        end
    end

    assign iter      = r_iter;
    assign last_iter = (r_iter == C_LAST);

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Sequencing controller for the iterative Goldschmidt divider.
//               Steps the shared multiplier through ITERS N*K / D*K pairs,
//               the remainder multiply and the rounding stage. All outputs
//               are decoded from registered state only.
//               Optional macro ROUND_Z_EN: latch rm at start and use it to
//               select round-toward-zero; without it rnd_z is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_pkg::*;
#(
    parameter int ITERS = 4,
    parameter int CW    = $clog2(ITERS + 1)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    div_ctrl_if.slave   bus
);

    div_state_t    r_state;
    div_state_t    w_next;
    logic          w_clr;
    logic          w_inc;
    logic          w_last_iter;
    logic [CW-1:0] w_iter;
    logic          w_rm_q;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

`ifdef ROUND_Z_EN
    logic r_rm;

    // Capture the rounding mode only when a divide is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rm <= RM_NE;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_rm <= bus.rm;
        end
    end

    assign w_rm_q = r_rm;
`else
    logic w_unused_rm;
    assign w_unused_rm = bus.rm;
    assign w_rm_q      = RM_NE;
`endif

    div_iter_cnt #(
        .ITERS (ITERS),
        .CW    (CW)
    ) u_iter_cnt (
        .clk       (clk),
        .reset     (reset),
        .clr       (w_clr),
        .inc       (w_inc),
        .iter      (w_iter),
        .last_iter (w_last_iter)
    );

    // Next-state and Moore output decode.
    always_comb begin
        w_next        = r_state;
        w_clr         = 1'b0;
        w_inc         = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.mul_a_sel = A_ZERO;
        bus.mul_b_sel = B_K;
        bus.ld_nd     = 1'b0;
        bus.ld_n      = 1'b0;
        bus.ld_d      = 1'b0;
        bus.ld_rem    = 1'b0;
        bus.round_en  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_next = S_LOAD;
                    w_clr  = 1'b1;
                end
            end
            S_LOAD: begin
                bus.ld_nd = 1'b1;
                w_next    = S_MUL_N;
            end
            S_MUL_N: begin
                bus.mul_a_sel = A_N;
                bus.ld_n      = 1'b1;
                w_next        = S_MUL_D;
            end
            S_MUL_D: begin
                bus.mul_a_sel = A_D;
                bus.ld_d      = 1'b1;
                w_inc         = 1'b1;
                w_next        = w_last_iter ? S_REM : S_MUL_N;
            end
            S_REM: begin
                bus.mul_a_sel = A_Q;
                bus.mul_b_sel = B_DIVISOR;
                bus.ld_rem    = 1'b1;
                w_next        = S_ROUND;
            end
            S_ROUND: begin
                bus.round_en = 1'b1;
                w_next       = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                bus.busy = 1'b0;
                w_next   = S_IDLE;
            end
        endcase
    end

    assign bus.rnd_z = w_rm_q;
    assign bus.iter  = w_iter;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl. Runs an ITERS=4 and an
//               ITERS=1 instance side by side on shared stimulus and checks
//               both against a cycle-count reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

`ifdef ROUND_Z_EN
    localparam bit C_RZ = 1'b1;
`else
    localparam bit C_RZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic r_start;
    logic r_rm;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    div_ctrl_if #(.ITERS(4)) bus4 ();
    div_ctrl_if #(.ITERS(1)) bus1 ();

    assign bus4.start = r_start;
    assign bus4.rm    = r_rm;
    assign bus1.start = r_start;
    assign bus1.rm    = r_rm;

    div_ctrl #(.ITERS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    div_ctrl #(.ITERS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    // Observed outputs packed as {busy,done,a_sel,b_sel,ld_nd,ld_n,ld_d,ld_rem,round_en,rnd_z,iter[3:0]}
    logic [14:0] w_obs4;
    logic [14:0] w_obs1;
    assign w_obs4 = {bus4.busy, bus4.done, bus4.mul_a_sel, bus4.mul_b_sel, bus4.ld_nd,
                     bus4.ld_n, bus4.ld_d, bus4.ld_rem, bus4.round_en, bus4.rnd_z,
                     1'b0, bus4.iter};
    assign w_obs1 = {bus1.busy, bus1.done, bus1.mul_a_sel, bus1.mul_b_sel, bus1.ld_nd,
                     bus1.ld_n, bus1.ld_d, bus1.ld_rem, bus1.round_en, bus1.rnd_z,
                     3'b000, bus1.iter};

    // Reference model: cycles elapsed since acceptance (0 = idle).
    int ph   [2] = '{0, 0};
    int held [2] = '{0, 0};
    bit mrm  [2] = '{0, 0};
    int itv  [2] = '{4, 1};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [14:0] expv(input int d);
        int p;
        int n;
        int it;
        logic [1:0] a;
        logic b, ldn, ldd, lrem;
        p = ph[d];
        n = itv[d];
        a = 2'd3; b = 1'b0; ldn = 1'b0; ldd = 1'b0; lrem = 1'b0;
        if (p >= 2 && p <= 2 * n + 1) begin
            if (p % 2 == 0) begin a = 2'd0; ldn = 1'b1; end
            else            begin a = 2'd1; ldd = 1'b1; end
        end
        if (p == 2 * n + 2) begin a = 2'd2; b = 1'b1; lrem = 1'b1; end
        if (p == 0)               it = held[d];
        else if (p == 1)          it = 0;
        else if (p <= 2 * n + 1)  it = (p - 2) / 2;
        else                      it = n;
        return {p != 0, p == 2 * n + 4, a, b, p == 1, ldn, ldd, lrem,
                p == 2 * n + 3, C_RZ & mrm[d], 4'(it)};
    endfunction

    // Model advance: one step per clock, asynchronous reset.
    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                ph[d] = 0; held[d] = 0; mrm[d] = 1'b0;
            end else if (ph[d] == 0) begin
                if (r_start) begin ph[d] = 1; mrm[d] = r_rm; held[d] = 0; end
            end else if (ph[d] == 2 * itv[d] + 4) begin
                ph[d] = 0; held[d] = itv[d];
            end else begin
                ph[d] = ph[d] + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("dut4_outputs", 32'(w_obs4), 32'(expv(0)));
        chk("dut1_outputs", 32'(w_obs1), 32'(expv(1)));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int first_done, last_done, n_done;

    initial begin
        reset = 1'b1; r_start = 1'b0; r_rm = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_a_sel", 32'(bus4.mul_a_sel), 32'd3);
        chk("reset_rnd_z", 32'(bus4.rnd_z), 32'd0);
        repeat (20) begin
            tick();
            chk("idle_busy", 32'(bus4.busy), 32'd0);
        end

        // Single divide, rm=0: literal timeline pins.
        r_start = 1'b1; r_rm = 1'b0;
        tick();
        r_start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 1)  chk("t1_ld_nd", 32'(bus4.ld_nd), 32'd1);
            if (k >= 2 && k <= 9) chk("t_ld_n_alt", 32'(bus4.ld_n), 32'(k % 2 == 0));
            if (k >= 2 && k <= 9) chk("t_ld_d_alt", 32'(bus4.ld_d), 32'(k % 2 == 1));
            if (k == 10) chk("t10_ld_rem", 32'(bus4.ld_rem), 32'd1);
            if (k == 11) chk("t11_round_en", 32'(bus4.round_en), 32'd1);
            if (k == 11) chk("t11_rnd_z", 32'(bus4.rnd_z), 32'd0);
            chk("done4_timing", 32'(bus4.done), 32'(k == 12));
            chk("done1_timing", 32'(bus1.done), 32'(k == 6));
            if (k == 13) chk("end_iter4", 32'(bus4.iter), 32'd4);
            if (k == 13) chk("end_iter1", 32'(bus1.iter), 32'd1);
            tick();
        end

        // rm=1 at start, toggled afterwards.
        r_start = 1'b1; r_rm = 1'b1;
        tick();
        r_start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            r_rm = ~r_rm;
            if (k == 11) chk("rm1_rnd_z", 32'(bus4.rnd_z), 32'(C_RZ));
            tick();
        end

        // start held high: done every 13 cycles.
        r_start = 1'b1; r_rm = 1'b0;
        n_done = 0; first_done = -1; last_done = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus4.done) begin
                if (first_done < 0) first_done = k;
                last_done = k;
                n_done++;
            end
        end
        r_start = 1'b0;
        chk("hold_done_count", 32'(n_done), 32'd3);
        chk("hold_done_span", 32'(last_done - first_done), 32'd26);
        repeat (15) tick();

        // Reset mid-iteration.
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus4.busy), 32'd0);
        chk("abort_a_sel", 32'(bus4.mul_a_sel), 32'd3);
        chk("abort_ld", 32'({bus4.ld_n, bus4.ld_d, bus4.ld_nd, bus4.ld_rem}), 32'd0);
        chk("abort_iter", 32'(bus4.iter), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) chk("post_reset_done", 32'(bus4.done), 32'd1);
            tick();
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2000; k++) begin
            r_start = ($urandom_range(0, 3) == 0);
            r_rm    = 1'($urandom_range(0, 1));
            reset   = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; r_start = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the iterative Goldschmidt divider datapath. It drives the single shared multiplier through the N·K / D·K iteration pairs, then the remainder multiply, then the rounding stage. At rounding it selects round-to-nearest-even or round-toward-zero. It sits between the FP-unit issue logic (start/done handshake) and the divider datapath registers and muxes.

## Interface
- ITERS, 4: number of Goldschmidt iterations, legal range 1..15.
- CW, $clog2(ITERS+1): iteration counter width. Derived; do not override.

- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new divide. Sampled only in IDLE.
- rm  in  1  rounding mode: 0 = nearest-even, 1 = toward-zero. Latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  single-cycle pulse when the rounded quotient is valid.
- mul_a_sel  out  2  multiplier A operand: 0 = N reg, 1 = D reg, 2 = Q reg, 3 = zero.
- mul_b_sel  out  1  multiplier B operand: 0 = K reg, 1 = original divisor.
- ld_nd  out  1  load N and D registers from operands (LOAD state).
- ld_n  out  1  write multiplier product into the N register.
- ld_d  out  1  write the product into the D register; also loads K = 2 − product.
- ld_rem  out  1  write the product into the remainder register.
- round_en  out  1  capture the rounder output into the result register.
- rnd_z  out  1  rounder select: 1 = round_z path, 0 = round_ne path.
- iter  out  CW  completed-iteration count, for debug/trace.

## Operation
- States: IDLE, LOAD, MUL_N, MUL_D, REM, ROUND, DONE. The encoding is defined in the package.
- IDLE: when start=1, go to LOAD, latch rm, and clear iter. When start=0, stay in IDLE.
- LOAD: assert ld_nd, then go to MUL_N.
- MUL_N: mul_a_sel=0, mul_b_sel=0, assert ld_n, then go to MUL_D.
- MUL_D: mul_a_sel=1, mul_b_sel=0, assert ld_d, and increment iter.
  - If iter+1 == ITERS, go to REM.
  - Otherwise go back to MUL_N.
- REM: mul_a_sel=2, mul_b_sel=1, assert ld_rem, then go to ROUND.
- ROUND: assert round_en, drive rnd_z = latched rm, then go to DONE.
- DONE: assert done, then go to IDLE.
- In every state not listed for an output:
  - All ld_*, round_en and done are 0.
  - mul_a_sel = 3 and mul_b_sel = 0.
  - rnd_z holds the latched rm.
- start is ignored in every state other than IDLE; it is neither queued nor an error.
- Changes to rm after acceptance have no effect on the operation in flight.
- iter saturates at ITERS and holds its value in REM, ROUND, DONE and IDLE until the next accepted start clears it.

## Timing
- All outputs are Moore and decoded from the registered state. There is no combinational path from inputs to outputs.
- Reset values (asynchronous, effective immediately):
  - state = IDLE, busy = 0, done = 0, iter = 0, latched rm = 0.
  - All ld_* = 0, round_en = 0, mul_a_sel = 3, mul_b_sel = 0, rnd_z = 0.
- Latency: start is sampled at edge T. Then LOAD is at T+1, the first MUL_N at T+2, REM at T+2+2·ITERS, and done is high in cycle T+4+2·ITERS. With ITERS = 4, done is at T+12.
- Back-to-back operation: the earliest next acceptance is the cycle after DONE, i.e. IDLE for at least one cycle. Peak throughput is one divide per 2·ITERS+5 cycles.
- busy is 1 in LOAD through DONE inclusive, and 0 in IDLE.
- Reset asserted mid-operation aborts it. No done pulse is produced, and datapath register contents are don't-care.

## Configuration
- ROUND_Z_EN defined:
  - rm is latched and drives rnd_z during ROUND as described above.
- ROUND_Z_EN undefined:
  - rm is ignored and the rm latch is not instantiated.
  - rnd_z is tied to 0, so the round_ne path is always used.
  - The port list is unchanged.

## Structure
- Package div_pkg contains:
  - the state enum div_state_t;
  - the mul_a_sel codes (A_N, A_D, A_Q, A_ZERO) and mul_b_sel codes (B_K, B_DIVISOR) as localparams/enums;
  - RM_NE = 0 and RM_Z = 1.
- One sub-module, div_iter_cnt: a clear/increment/saturate counter parameterised by ITERS. It produces iter and a last_iter flag.
- The FSM next-state logic and output decode stay in div_ctrl.

## Test plan
- Reset, then idle: check every output equals its reset value, and busy stays 0 with start=0 for 20 cycles.
- ITERS=4, one start pulse at T with rm=0:
  - ld_nd at T+1;
  - ld_n/ld_d alternate over T+2..T+9;
  - ld_rem at T+10, round_en at T+11 with rnd_z=0;
  - done at T+12 only; iter = 4 at the end.
- rm=1 at start, then toggle rm during the operation: rnd_z is 1 in ROUND with ROUND_Z_EN defined, and 0 without it.
- Hold start=1 continuously: done pulses every 13 cycles, and no start is accepted while busy=1.
- Assert reset at T+6 mid-iteration: outputs return to reset values immediately, with no done pulse. A new start 2 cycles after reset is released completes normally.
- ITERS=1: the sequence is LOAD, MUL_N, MUL_D, REM, ROUND, DONE, with done at T+6.
